// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
// Holds the arbiter FSM state encoding and the requester index constants.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] oh;
    if (idx == REQ_LOADER) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter: two request channels plus
// the shared accept/completion/read-data returns.
interface regfile_arbiter_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_SIZE = 5
);
  logic [1:0]           req_valid;
  logic [1:0]           req_we;
  logic [ADDR_SIZE-1:0] req_addr0;
  logic [ADDR_SIZE-1:0] req_addr1;
  logic [WIDTH-1:0]     req_wdata0;
  logic [WIDTH-1:0]     req_wdata1;
  logic [1:0]           req_ready;
  logic [1:0]           done;
  logic [WIDTH-1:0]     rdata;

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, done, rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, done, rdata
  );
endinterface

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way round-robin selector: a lone valid requester always wins, a tie
// goes to the requester named by ptr.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant from the valid pair and the tie-break pointer
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = req_onehot(ptr);
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto one register-file port; each accepted
// request runs IDLE -> ISSUE -> RESP and ends with a one-cycle done pulse.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_arbiter_if.slave     bus,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] rf_a1,
  output logic [ADDR_SIZE-1:0] rf_a2,
  output logic [WIDTH-1:0]     rf_wdata,
  output logic                 rf_we,
  input  logic [WIDTH-1:0]     rf_rd1
);

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 ptr_r;
  logic                 win_r;
  logic                 we_r;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [WIDTH-1:0]     wdata_r;
  logic [WIDTH-1:0]     rdata_r;
  logic                 rf_we_r;
  logic [1:0]           done_r;
  logic [1:0]           grant_s;
  logic [1:0]           ready_s;
  logic                 hs_s;
  logic                 hs_idx_s;
  logic                 sel_we_s;
  logic [ADDR_SIZE-1:0] sel_addr_s;
  logic [WIDTH-1:0]     sel_wdata_s;

  rr_arbiter2 u_rr (
    .valid (bus.req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Accept strobe only in IDLE and never while reset is held
  always_comb begin
    ready_s = 2'b00;
    if ((state_r == IDLE) && !rst) begin
      ready_s = grant_s;
    end else begin
      ready_s = 2'b00;
    end
  end

  assign hs_s     = |(bus.req_valid & ready_s);
  assign hs_idx_s = ready_s[1];

  // Route the winning requester's fields toward the latch
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (hs_idx_s == REQ_LOADER) begin
      sel_we_s    = bus.req_we[1];
      sel_addr_s  = bus.req_addr1;
      sel_wdata_s = bus.req_wdata1;
    end else begin
      sel_we_s    = bus.req_we[0];
      sel_addr_s  = bus.req_addr0;
      sel_wdata_s = bus.req_wdata0;
    end
  end

  // Next-state logic; leaving IDLE requires a handshake
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:   state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, request latch, pointer and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= REQ_CORE;
      win_r   <= REQ_CORE;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      rf_we_r <= 1'b0;
      done_r  <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      if (hs_s) begin
        win_r   <= hs_idx_s;
        we_r    <= sel_we_s;
        addr_r  <= sel_addr_s;
        wdata_r <= sel_wdata_s;
        ptr_r   <= ~hs_idx_s;
        rf_we_r <= sel_we_s;
      end else begin
        rf_we_r <= 1'b0;
      end
      if (state_r == ISSUE) begin
        done_r <= req_onehot(win_r);
        if (!we_r) begin
          rdata_r <= rf_rd1;
        end else begin
          rdata_r <= rdata_r;
        end
      end else begin
        done_r <= 2'b00;
      end
    end
  end

  assign busy          = (state_r != IDLE);
  assign rf_a1         = addr_r;
  assign rf_a2         = addr_r;
  assign rf_wdata      = wdata_r;
  assign rf_we         = rf_we_r;
  assign bus.req_ready = ready_s;
  assign bus.done      = done_r;
  assign bus.rdata     = rdata_r;

endmodule
